// File: rtl/rst_seq.sv
// Power-on / re-sequencing reset generator with staged per-output release.
// Optional watchdog re-sequence enabled by defining RST_SEQ_WDT_EN.
module rst_seq #(
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STAGE_GAP   = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned WDT_CYCLES  = 256
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ext_rst_i,
  input  logic               sw_rst_i,
  input  logic               kick_i,
  output logic [NUM_OUT-1:0] rst_o,
  output logic               done_o,
  output logic [1:0]         cause_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int IW = $clog2(NUM_OUT + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(FILT_LEN);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_HOLD,
    S_STAGE,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [FW-1:0]      filt_q, filt_d;
  logic               sync1_q, sync2_q;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic [1:0]         cause_q, cause_d;

  logic ext_req;
  logic wdt_exp;
  logic start_stage;
  logic step;

  // ext request: 2-flop sync then saturating run-length filter
  always_comb begin
    filt_d = '0;
    if (sync2_q) begin
      filt_d = (filt_q >= FILT_MAX) ? filt_q : filt_q + 1'b1;
    end
  end

  assign ext_req = (filt_q >= FILT_MAX);

`ifdef RST_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_MAX = WW'(WDT_CYCLES);

  logic [WW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = '0;
    if (state_q == S_RUN && state_d == S_RUN && !kick_i) begin
      wdt_d = (wdt_q >= WDT_MAX) ? wdt_q : wdt_q + 1'b1;
    end
  end

  assign wdt_exp = (state_q == S_RUN) && (wdt_q >= WDT_MAX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_kick;
  assign unused_kick = kick_i;
  assign wdt_exp     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    rst_d       = rst_q;
    done_d      = done_q;
    cause_d     = cause_q;
    start_stage = 1'b0;
    step        = 1'b0;

    unique case (state_q)
      S_ASSERT: begin
        if (!ext_req) begin
          state_d = S_HOLD;
          hold_d  = HW'(1);
          gap_d   = '0;
          idx_d   = '0;
          if (HOLD_CYCLES <= 1) start_stage = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q >= HOLD_LAST) begin
          start_stage = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_STAGE: begin
        if (gap_q >= GAP_LAST) begin
          step = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RUN: ;
      default: state_d = S_ASSERT;
    endcase

    if (start_stage) begin
      rst_d[0] = 1'b0;
      gap_d    = '0;
      idx_d    = IW'(1);
      if (NUM_OUT == 1) begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end else begin
        state_d = S_STAGE;
      end
    end

    if (step) begin
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        if (idx_q == IW'(i)) rst_d[i] = 1'b0;
      end
      gap_d = '0;
      idx_d = idx_q + 1'b1;
      if (idx_q >= IDX_LAST) begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end
    end

    // ext > watchdog > sw; rst_ni handled in the register block
    if (state_q != S_ASSERT && (ext_req || wdt_exp || sw_rst_i)) begin
      state_d = S_ASSERT;
      rst_d   = '1;
      done_d  = 1'b0;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      if (ext_req)      cause_d = 2'b01;
      else if (wdt_exp) cause_d = 2'b11;
      else              cause_d = 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      filt_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      filt_q  <= filt_d;
      sync1_q <= ext_rst_i;
      sync2_q <= sync1_q;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_o   = rst_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed self-checking bench for rst_seq (defaults, WDT_CYCLES=16).
// Watchdog scenarios build only when RST_SEQ_WDT_EN is defined.
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ext_rst_i;
  logic       sw_rst_i;
  logic       kick_i;
  logic [2:0] rst_o;
  logic       done_o;
  logic [1:0] cause_o;

  int checks = 0;
  int errors = 0;

  rst_seq #(
    .NUM_OUT    (3),
    .HOLD_CYCLES(4),
    .STAGE_GAP  (2),
    .FILT_LEN   (3),
    .WDT_CYCLES (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ext_rst_i(ext_rst_i),
    .sw_rst_i (sw_rst_i),
    .kick_i   (kick_i),
    .rst_o    (rst_o),
    .done_o   (done_o),
    .cause_o  (cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // release pattern for edge e counted from the first edge after ASSERT
  function automatic logic [2:0] exp_rst(int e);
    logic [2:0] r;
    r = 3'b111;
    for (int i = 0; i < 3; i++) begin
      if (e >= 4 + 2 * i) r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++;
    if (rst_o !== 3'b111 || done_o !== 1'b0 || cause_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_state rst=%b done=%b cause=%b exp 111/0/00",
               rst_o, done_o, cause_o);
    end
    rst_ni = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (rst_o !== exp_rst(e) || done_o !== (e >= 8) ||
          cause_o !== 2'b00) begin
        errors++;
        $display("FAIL por_seq e=%0d rst=%b done=%b cause=%b exp %b/%b/00",
                 e, rst_o, done_o, cause_o, exp_rst(e), (e >= 8));
      end
    end
  endtask

  task automatic test_sw_run();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    checks++;
    if (rst_o !== 3'b111 || done_o !== 1'b0 || cause_o !== 2'b10) begin
      errors++;
      $display("FAIL sw_assert rst=%b done=%b cause=%b exp 111/0/10",
               rst_o, done_o, cause_o);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (rst_o !== exp_rst(e) || done_o !== (e >= 8) ||
          cause_o !== 2'b10) begin
        errors++;
        $display("FAIL sw_reseq e=%0d rst=%b done=%b cause=%b exp %b/%b/10",
                 e, rst_o, done_o, cause_o, exp_rst(e), (e >= 8));
      end
    end
  endtask

  task automatic test_ext_short();
    int bad;
    bad = 0;
    ext_rst_i = 1'b1;
    repeat (2) tick();
    ext_rst_i = 1'b0;
    repeat (10) begin
      tick();
      if (rst_o !== 3'b000 || done_o !== 1'b1 || cause_o !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ext_short bad_cycles=%0d exp 0 (rst=%b cause=%b)",
               bad, rst_o, cause_o);
    end
  endtask

  task automatic test_ext_long();
    logic [2:0] er;
    logic       ed;
    ext_rst_i = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 10) ext_rst_i = 1'b0;
      if (k < 6) begin
        er = 3'b000;
        ed = 1'b1;
      end else if (k < 14) begin
        er = 3'b111;
        ed = 1'b0;
      end else begin
        er = exp_rst(k - 13);
        ed = (k - 13 >= 8);
      end
      if (k == 5 || k == 6 || k == 13 || k == 16 || k == 17 ||
          k == 19 || k == 21) begin
        checks++;
        if (rst_o !== er || done_o !== ed ||
            cause_o !== (k < 6 ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL ext_long k=%0d rst=%b done=%b cause=%b exp %b/%b",
                   k, rst_o, done_o, cause_o, er, ed);
        end
      end
    end
  endtask

  task automatic test_sw_mid();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (4) tick();
    checks++;
    if (rst_o !== 3'b110) begin
      errors++;
      $display("FAIL mid_pre rst=%b exp 110", rst_o);
    end
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    checks++;
    if (rst_o !== 3'b111 || done_o !== 1'b0 || cause_o !== 2'b10) begin
      errors++;
      $display("FAIL mid_assert rst=%b done=%b cause=%b exp 111/0/10",
               rst_o, done_o, cause_o);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3 || e == 4 || e == 6 || e == 8) begin
        checks++;
        if (rst_o !== exp_rst(e) || done_o !== (e >= 8)) begin
          errors++;
          $display("FAIL mid_reseq e=%0d rst=%b done=%b exp %b/%b",
                   e, rst_o, done_o, exp_rst(e), (e >= 8));
        end
      end
    end
  endtask

  task automatic test_priority();
    int n;
    ext_rst_i = 1'b1;
    repeat (5) tick();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i  = 1'b0;
    ext_rst_i = 1'b0;
    checks++;
    if (rst_o !== 3'b111 || cause_o !== 2'b01) begin
      errors++;
      $display("FAIL prio_ext_sw rst=%b cause=%b exp 111/01", rst_o, cause_o);
    end
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (done_o !== 1'b1 || rst_o !== 3'b000) begin
      errors++;
      $display("FAIL prio_recover done=%b rst=%b exp 1/000", done_o, rst_o);
    end
    rst_ni   = 1'b0;
    sw_rst_i = 1'b1;
    tick();
    rst_ni   = 1'b1;
    sw_rst_i = 1'b0;
    checks++;
    if (rst_o !== 3'b111 || cause_o !== 2'b00 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_rstn_sw rst=%b cause=%b done=%b exp 111/00/0",
               rst_o, cause_o, done_o);
    end
    repeat (8) tick();
    checks++;
    if (done_o !== 1'b1 || cause_o !== 2'b00) begin
      errors++;
      $display("FAIL prio_rstn_done done=%b cause=%b exp 1/00",
               done_o, cause_o);
    end
  endtask

`ifdef RST_SEQ_WDT_EN
  task automatic fresh_seq();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_wdt_expire();
    fresh_seq();
    repeat (16) tick();
    checks++;
    if (done_o !== 1'b1 || rst_o !== 3'b000) begin
      errors++;
      $display("FAIL wdt_early done=%b rst=%b exp 1/000", done_o, rst_o);
    end
    tick();
    checks++;
    if (rst_o !== 3'b111 || done_o !== 1'b0 || cause_o !== 2'b11) begin
      errors++;
      $display("FAIL wdt_expire rst=%b done=%b cause=%b exp 111/0/11",
               rst_o, done_o, cause_o);
    end
  endtask

  task automatic test_wdt_kick();
    int bad;
    bad = 0;
    fresh_seq();
    for (int i = 0; i < 200; i++) begin
      kick_i = (i % 10 == 9);
      tick();
      if (done_o !== 1'b1) bad++;
    end
    kick_i = 1'b0;
    checks++;
    if (bad != 0 || cause_o !== 2'b00) begin
      errors++;
      $display("FAIL wdt_kick bad_cycles=%0d cause=%b exp 0/00",
               bad, cause_o);
    end
  endtask

  task automatic test_wdt_rstn();
    fresh_seq();
    repeat (16) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checks++;
    if (rst_o !== 3'b111 || cause_o !== 2'b00) begin
      errors++;
      $display("FAIL wdt_rstn rst=%b cause=%b exp 111/00", rst_o, cause_o);
    end
  endtask
`endif

  initial begin
    rst_ni    = 1'b0;
    ext_rst_i = 1'b0;
    sw_rst_i  = 1'b0;
    kick_i    = 1'b0;
    test_reset();
    test_sw_run();
    test_ext_short();
    test_ext_long();
    test_sw_mid();
    test_priority();
`ifdef RST_SEQ_WDT_EN
    test_wdt_expire();
    test_wdt_kick();
    test_wdt_rstn();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
